// File: rtl/eth_recv.sv
// ---------------------------------------------------------------------------
// eth_recv: receive-side parser for timestamp probe frames.
//
// Frames arrive on a 64-bit AXI-Stream with no back-pressure. The first three
// beats carry the header fields of interest: beat 1 holds the EtherType and
// the sequence number, and beat 2 holds the big-endian transmit timestamp.
// On the tlast beat each frame is classified as an FCS error, a drop (runt or
// foreign EtherType) or a good probe. A good probe produces a one-cycle
// result pulse with its sequence number and its latency (rx_time - tx_time).
//
// Optional feature macro: ETH_RECV_MINMAX_EN adds the lat_min / lat_max
// running statistics and their ports.
//
// Ports:
//   clk156            single clock, rising edge
//   reset             asynchronous active-high reset
//   s_axis_rx_tvalid  beat valid
//   s_axis_rx_tlast   last beat of frame
//   s_axis_rx_tuser   on the tlast beat: 1 = good FCS
//   s_axis_rx_tdata   64-bit beat, [7:0] is the earliest byte on the wire
//   s_axis_rx_tkeep   byte enables (ignored)
//   stats_clear       synchronous clear of counters and statistics
//   ts_now            free-running timestamp counter
//   result_valid      one-cycle pulse per good probe
//   result_seq        sequence number of the last good probe
//   result_latency    latency of the last good probe
//   frame_count       good probes
//   err_count         frames with bad FCS
//   drop_count        runts and frames with a foreign EtherType
//   lat_min/lat_max   latency extremes (only with ETH_RECV_MINMAX_EN)
// ---------------------------------------------------------------------------
module eth_recv #(
    parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
    input  logic        clk156,
    input  logic        reset,
    input  logic        s_axis_rx_tvalid,
    input  logic        s_axis_rx_tlast,
    input  logic        s_axis_rx_tuser,
    input  logic [63:0] s_axis_rx_tdata,
    input  logic [7:0]  s_axis_rx_tkeep,
    input  logic        stats_clear,
    output logic [31:0] ts_now,
    output logic        result_valid,
    output logic [15:0] result_seq,
    output logic [31:0] result_latency,
    output logic [31:0] frame_count,
    output logic [31:0] err_count,
`ifdef ETH_RECV_MINMAX_EN
    output logic [31:0] lat_min,
    output logic [31:0] lat_max,
`endif
    output logic [31:0] drop_count
);

    typedef enum logic [1:0] {
        BEAT0 = 2'd0,
        BEAT1 = 2'd1,
        BEAT2 = 2'd2,
        TAIL  = 2'd3
    } state_t;

    // Wire order is big-endian: the byte at the lowest lane is the MSB.
    function automatic logic [15:0] bswap16(input logic [15:0] v);
        return {v[7:0], v[15:8]};
    endfunction

    function automatic logic [31:0] bswap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    state_t      state_r;
    state_t      state_s;
    logic [31:0] rx_time_r;
    logic [31:0] tx_time_r;
    logic [15:0] ethertype_r;
    logic [15:0] seq_r;
    logic [31:0] tx_time_s;
    logic        last_beat_s;
    logic        runt_s;
    logic        is_err_s;
    logic        is_drop_s;
    logic        is_good_s;
    logic        unused_s;

    // Byte enables carry no information the parser needs.
    assign unused_s = ^s_axis_rx_tkeep;

    // Next-state: advance one header state per accepted beat, tlast restarts.
    always_comb begin
        state_s = state_r;
        if (s_axis_rx_tvalid) begin
            if (s_axis_rx_tlast) begin
                state_s = BEAT0;
            end else begin
                case (state_r)
                    BEAT0:   state_s = BEAT1;
                    BEAT1:   state_s = BEAT2;
                    BEAT2:   state_s = TAIL;
                    TAIL:    state_s = TAIL;
                    default: state_s = BEAT0;
                endcase
            end
        end else begin
            state_s = state_r;
        end
    end

    // Classification of the frame ending on this beat, first match wins.
    always_comb begin
        last_beat_s = s_axis_rx_tvalid & s_axis_rx_tlast;
        // A frame ending on its BEAT2 beat still carries a complete header,
        // so its timestamp is taken straight from the bus.
        runt_s      = (state_r == BEAT0) || (state_r == BEAT1);
        if (state_r == BEAT2) begin
            tx_time_s = bswap32(s_axis_rx_tdata[31:0]);
        end else begin
            tx_time_s = tx_time_r;
        end
        is_err_s  = last_beat_s & ~s_axis_rx_tuser;
        is_drop_s = last_beat_s & s_axis_rx_tuser &
                    (runt_s | (ethertype_r != ETHERTYPE));
        is_good_s = last_beat_s & s_axis_rx_tuser & ~runt_s &
                    (ethertype_r == ETHERTYPE);
    end

    // Free-running timestamp.
    always_ff @(posedge clk156 or posedge reset) begin
        if (reset) begin
            ts_now <= 32'd0;
        end else begin
            ts_now <= ts_now + 32'd1;
        end
    end

    // Parser state register.
    always_ff @(posedge clk156 or posedge reset) begin
        if (reset) begin
            state_r <= BEAT0;
        end else begin
            state_r <= state_s;
        end
    end

    // Header field capture on the beat that carries each field.
    always_ff @(posedge clk156 or posedge reset) begin
        if (reset) begin
            rx_time_r   <= 32'd0;
            tx_time_r   <= 32'd0;
            ethertype_r <= 16'd0;
            seq_r       <= 16'd0;
        end else if (s_axis_rx_tvalid) begin
            case (state_r)
                BEAT0: rx_time_r <= ts_now;
                BEAT1: begin
                    ethertype_r <= bswap16(s_axis_rx_tdata[47:32]);
                    seq_r       <= bswap16(s_axis_rx_tdata[63:48]);
                end
                BEAT2: tx_time_r <= bswap32(s_axis_rx_tdata[31:0]);
                TAIL:  tx_time_r <= tx_time_r;
                default: rx_time_r <= rx_time_r;
            endcase
        end
    end

    // Result pulse and held result fields.
    always_ff @(posedge clk156 or posedge reset) begin
        if (reset) begin
            result_valid   <= 1'b0;
            result_seq     <= 16'd0;
            result_latency <= 32'd0;
        end else begin
            result_valid <= is_good_s;
            if (is_good_s) begin
                result_seq     <= seq_r;
                result_latency <= rx_time_r - tx_time_s;
            end
        end
    end

    // Event counters; a clear wins over a coincident increment.
    always_ff @(posedge clk156 or posedge reset) begin
        if (reset) begin
            frame_count <= 32'd0;
            err_count   <= 32'd0;
            drop_count  <= 32'd0;
        end else if (stats_clear) begin
            frame_count <= 32'd0;
            err_count   <= 32'd0;
            drop_count  <= 32'd0;
        end else begin
            frame_count <= frame_count + {31'd0, is_good_s};
            err_count   <= err_count   + {31'd0, is_err_s};
            drop_count  <= drop_count  + {31'd0, is_drop_s};
        end
    end

`ifdef ETH_RECV_MINMAX_EN
    // Latency extremes, folded in while the result is being presented.
    always_ff @(posedge clk156 or posedge reset) begin
        if (reset) begin
            lat_min <= 32'hFFFF_FFFF;
            lat_max <= 32'd0;
        end else if (stats_clear) begin
            lat_min <= 32'hFFFF_FFFF;
            lat_max <= 32'd0;
        end else if (result_valid) begin
            if (result_latency < lat_min) begin
                lat_min <= result_latency;
            end
            if (result_latency > lat_max) begin
                lat_max <= result_latency;
            end
        end
    end
`endif

endmodule
